// File: rtl/pipe_pkg.sv
// Shared types and constants for the IF/ID instruction fetch queue.
package pipe_pkg;
   localparam int INST_W  = 32;
   localparam int ENTRY_W = 64;
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [INST_W-1:0] pc4;
   } ifq_entry_t;
endpackage

// File: rtl/ifq_regfile.sv
// DEPTH x ENTRY_W storage: synchronous write, asynchronous read, no reset.
module ifq_regfile
   import pipe_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic               clock,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [ENTRY_W-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [ENTRY_W-1:0] rdata
);
   logic [DEPTH-1:0][ENTRY_W-1:0] mem;

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/pipe_ifq.sv
// Instruction fetch queue between IF and ID: first-word-fall-through head,
// single-cycle flush of all entries on a taken branch or jump.
module pipe_ifq
   import pipe_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_valid,
   input  logic [INST_W-1:0] if_inst,
   input  logic [INST_W-1:0] if_pc4,
   output logic              if_ready,
   input  logic              id_ready,
   output logic              id_valid,
   output logic [INST_W-1:0] id_inst,
   output logic [INST_W-1:0] id_pc4,
   input  logic              flush,
   output logic [AW:0]       count
);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [AW-1:0] rd_ptr, wr_ptr;
   logic          push, pop;
   ifq_entry_t    wr_entry, rd_entry;

   // Ready/valid come from registered count only, so id_ready never
   // reaches if_ready combinationally.
   assign if_ready = (count != FULL);
   assign id_valid = (count != '0);

   assign push = if_valid & if_ready & ~flush & ~reset;
   assign pop  = id_ready & id_valid & ~flush & ~reset;

   assign wr_entry = '{inst: if_inst, pc4: if_pc4};

   ifq_regfile #(.DEPTH(DEPTH), .AW(AW)) u_rf (
      .clock (clock),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (rd_entry)
   );

   // Storage is never cleared; gating here keeps NOP on id_* while empty.
   assign id_inst = id_valid ? rd_entry.inst : NOP_INST;
   assign id_pc4  = id_valid ? rd_entry.pc4  : '0;

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_pipe_ifq.sv
// Directed bench for pipe_ifq: ordering, full/empty, wrap, flush and reset.
module tb_pipe_ifq;
   logic        clock = 1'b0;
   logic        reset, if_valid, id_ready, flush;
   logic [31:0] if_inst, if_pc4;
   logic        if_ready, id_valid;
   logic [31:0] id_inst, id_pc4;
   logic [2:0]  count;
   int          checks = 0;
   int          errors = 0;

   pipe_ifq #(.DEPTH(4), .AW(2)) dut (
      .clock    (clock),
      .reset    (reset),
      .if_valid (if_valid),
      .if_inst  (if_inst),
      .if_pc4   (if_pc4),
      .if_ready (if_ready),
      .id_ready (id_ready),
      .id_valid (id_valid),
      .id_inst  (id_inst),
      .id_pc4   (id_pc4),
      .flush    (flush),
      .count    (count)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_set(input logic [31:0] inst, input logic [31:0] pc4);
      if_valid = 1'b1;
      if_inst  = inst;
      if_pc4   = pc4;
   endtask

   initial begin
      reset = 1'b1; if_valid = 1'b0; id_ready = 1'b0; flush = 1'b0;
      if_inst = '0; if_pc4 = '0;
      step(); step();
      reset = 1'b0;

      // idle after reset
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_count", 32'(count), 0);
         chk("rst_if_ready", 32'(if_ready), 1);
         chk("rst_id_valid", 32'(id_valid), 0);
         chk("rst_id_inst", id_inst, 32'h0);
         chk("rst_id_pc4", id_pc4, 32'h0);
      end

      // two pushes held, then drained in order
      push_set(32'h2008_0005, 32'h4);
      step();
      chk("p1_count", 32'(count), 1);
      chk("p1_head", id_inst, 32'h2008_0005);
      push_set(32'h2009_0007, 32'h8);
      step();
      if_valid = 1'b0;
      chk("p2_count", 32'(count), 2);
      chk("p2_head", id_inst, 32'h2008_0005);
      chk("p2_pc4", id_pc4, 32'h4);
      id_ready = 1'b1;
      step();
      chk("pop1_head", id_inst, 32'h2009_0007);
      chk("pop1_pc4", id_pc4, 32'h8);
      chk("pop1_count", 32'(count), 1);
      step();
      chk("pop2_count", 32'(count), 0);
      chk("pop2_valid", 32'(id_valid), 0);
      chk("pop2_inst", id_inst, 32'h0);
      id_ready = 1'b0;

      // fill to DEPTH
      for (int i = 0; i < 4; i++) begin
         push_set(32'h1000_0000 + i, 32'h100 + 4*i);
         step();
      end
      chk("full_count", 32'(count), 4);
      chk("full_if_ready", 32'(if_ready), 0);
      push_set(32'hDEAD_BEEF, 32'hFFF0);
      step();
      chk("full_reject_count", 32'(count), 4);
      chk("full_head", id_inst, 32'h1000_0000);
      // pop while full with if_valid still high: only the pop happens
      id_ready = 1'b1;
      step();
      if_valid = 1'b0;
      chk("full_pop_count", 32'(count), 3);
      chk("full_pop_if_ready", 32'(if_ready), 1);
      for (int i = 1; i < 4; i++) begin
         chk("drain_head", id_inst, 32'h1000_0000 + i);
         chk("drain_pc4", id_pc4, 32'h100 + 4*i);
         step();
      end
      chk("drain_count", 32'(count), 0);
      chk("drain_valid", 32'(id_valid), 0);
      id_ready = 1'b0;

      // interleaved push/pop across pointer wrap
      push_set(32'h3000_0000, 32'h200); step();
      push_set(32'h3000_0001, 32'h204); step();
      id_ready = 1'b1;
      for (int i = 2; i < 6; i++) begin
         push_set(32'h3000_0000 + i, 32'h200 + 4*i);
         chk("wrap_head", id_inst, 32'h3000_0000 + i - 2);
         step();
         chk("wrap_count", 32'(count), 2);
      end
      if_valid = 1'b0;
      chk("wrap_tail0", id_inst, 32'h3000_0004);
      step();
      chk("wrap_tail1", id_inst, 32'h3000_0005);
      chk("wrap_tail1_pc4", id_pc4, 32'h214);
      step();
      chk("wrap_empty", 32'(count), 0);
      id_ready = 1'b0;

      // flush with concurrent push and pop at count=3
      for (int i = 0; i < 3; i++) begin
         push_set(32'h4000_0000 + i, 32'h300 + 4*i);
         step();
      end
      chk("pre_flush_count", 32'(count), 3);
      push_set(32'hBAD0_0001, 32'h9990);
      id_ready = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
      chk("flush_count", 32'(count), 0);
      chk("flush_valid", 32'(id_valid), 0);
      chk("flush_if_ready", 32'(if_ready), 1);
      chk("flush_inst", id_inst, 32'h0);
      step();
      chk("flush_dropped", 32'(count), 0);
      push_set(32'h5000_0000, 32'h400);
      step();
      if_valid = 1'b0;
      chk("post_flush_head", id_inst, 32'h5000_0000);
      chk("post_flush_count", 32'(count), 1);
      id_ready = 1'b1;
      step();
      id_ready = 1'b0;
      chk("post_flush_empty", 32'(count), 0);

      // reset mid-operation with a pending push
      push_set(32'h6000_0000, 32'h500); step();
      push_set(32'h6000_0001, 32'h504); step();
      chk("pre_rst_count", 32'(count), 2);
      push_set(32'hBAD0_0002, 32'h9994);
      reset = 1'b1;
      step();
      reset = 1'b0; if_valid = 1'b0;
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_inst", id_inst, 32'h0);
      chk("mid_rst_valid", 32'(id_valid), 0);
      push_set(32'h7000_0000, 32'h600);
      step();
      if_valid = 1'b0;
      chk("resume_head", id_inst, 32'h7000_0000);
      chk("resume_pc4", id_pc4, 32'h600);
      chk("resume_count", 32'(count), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
